// File: rtl/dct_tp_pkg.sv
// Shared constants and types for the 8x8 DCT transpose buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: block geometry (DCT_N, DCT_IDX_W), the per-bank state
// encoding, a default-width word type and small state-decode helpers.
package dct_tp_pkg;

    localparam int DCT_N     = 8;
    localparam int DCT_IDX_W = 3;

    // Default coefficient width; modules carry their own DATA_W parameter
    // and build local vector types from it.
    localparam int TP_WORD_W = 32;

    typedef logic [TP_WORD_W-1:0] tp_word_t;
    typedef logic [DCT_IDX_W-1:0] tp_idx_t;

    typedef enum logic [1:0] {
        TP_EMPTY,
        TP_FILLING,
        TP_FULL,
        TP_DRAINING
    } tp_bank_state_t;

    // A bank may take rows until its eighth row has landed.
    function automatic logic tp_is_writable(input tp_bank_state_t st);
        return (st == TP_EMPTY) || (st == TP_FILLING);
    endfunction

    // A bank may present columns only once all eight rows are in.
    function automatic logic tp_is_readable(input tp_bank_state_t st);
        return (st == TP_FULL) || (st == TP_DRAINING);
    endfunction

endpackage

// File: rtl/dct_tp_bank.sv
// One 8x8 word store: row-wide write port, column-wide combinational read.
// Latency: write lands on the rising edge with we=1; read is combinational from col.
// Backpressure: none here; the parent only asserts we on an accepted row.
//
// Ports:
//   clk     rising-edge clock
//   we      write the row vector this cycle
//   row     row index written (0..7)
//   wr_vec  eight words, element c goes to column c
//   col     column index read (0..7)
//   rd_vec  eight words, element r is mem[r][col]
// Storage is intentionally not reset: a bank is only ever read after all
// eight rows have been written since the last reset.
module dct_tp_bank
    import dct_tp_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                            clk,
    input  logic                            we,
    input  logic [DCT_IDX_W-1:0]            row,
    input  logic [DCT_N-1:0][DATA_W-1:0]    wr_vec,
    input  logic [DCT_IDX_W-1:0]            col,
    output logic [DCT_N-1:0][DATA_W-1:0]    rd_vec
);

    logic [DATA_W-1:0] mem [DCT_N][DCT_N];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int c = 0; c < DCT_N; c++) begin
                mem[row][c] <= wr_vec[c];
            end
        end
    end

    // Column read: pick element col out of every row.
    always_comb begin
        rd_vec = '0;
        for (int r = 0; r < DCT_N; r++) begin
            rd_vec[r] = mem[r][col];
        end
    end

endmodule

// File: rtl/dct8_transpose_pp.sv
// Ping-pong 8x8 transpose: accepts 8 rows per block, emits the same block as 8 columns.
// Latency: column 0 is valid the cycle after the row-7 handshake (9 cycles from row 0).
// Backpressure: in_ready drops only while the write bank is FULL/DRAINING; outputs hold while out_ready=0.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    row handshake, in0..in7 = columns 0..7 of the row
//   out_valid / out_ready  column handshake, out0..out7 = rows 0..7 of the column
// Build option: DCT_TP_SINGLE_BANK_EN keeps only bank 0 (wb/rb tied to 0),
// halving throughput; the default build is the two-bank ping-pong.
module dct8_transpose_pp
    import dct_tp_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] in4,
    input  logic [DATA_W-1:0] in5,
    input  logic [DATA_W-1:0] in6,
    input  logic [DATA_W-1:0] in7,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic [DATA_W-1:0] out4,
    output logic [DATA_W-1:0] out5,
    output logic [DATA_W-1:0] out6,
    output logic [DATA_W-1:0] out7
);

    localparam logic [DCT_IDX_W-1:0] LAST_IDX = DCT_IDX_W'(DCT_N - 1);

    typedef logic [DCT_N-1:0][DATA_W-1:0] vec_t;

    vec_t                 wr_vec;
    vec_t                 rd_vec [2];
    vec_t                 rd_sel;
    vec_t                 out_vec;
    tp_bank_state_t       bank_st [2];
    logic                 wb;
    logic                 rb;
    logic [DCT_IDX_W-1:0] wr_row;
    logic [DCT_IDX_W-1:0] rd_col;
    logic                 in_fire;
    logic                 out_fire;
    logic                 wr_last;
    logic                 rd_last;

    assign wr_vec = {in7, in6, in5, in4, in3, in2, in1, in0};

    // Handshake decode straight from bank state: no combinational path
    // from in_valid to out_valid or from out_ready to in_ready.
    assign in_ready  = tp_is_writable(bank_st[wb]);
    assign out_valid = tp_is_readable(bank_st[rb]);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign wr_last   = (wr_row == LAST_IDX);
    assign rd_last   = (rd_col == LAST_IDX);

    // ------------------------------------------------------------------
    // Bank pointers
    // ------------------------------------------------------------------
`ifdef DCT_TP_SINGLE_BANK_EN
    localparam int NB = 1;

    assign wb = 1'b0;
    assign rb = 1'b0;
`else
    localparam int NB = 2;

    // Each side flips to the other bank after handling its eighth vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb <= 1'b0;
            rb <= 1'b0;
        end else begin
            if (in_fire && wr_last) begin
                wb <= ~wb;
            end
            if (out_fire && rd_last) begin
                rb <= ~rb;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Row / column counters (3-bit, wrap naturally from 7 to 0)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_row <= '0;
            rd_col <= '0;
        end else begin
            if (in_fire) begin
                wr_row <= wr_row + 1'b1;
            end
            if (out_fire) begin
                rd_col <= rd_col + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-bank state machines
    // A write and a read can never target the same bank in one cycle:
    // writes need EMPTY/FILLING, reads need FULL/DRAINING. So the two
    // branches are exclusive per bank, and a bank drained on the same
    // edge the writer is waiting on it only becomes EMPTY at that edge,
    // raising in_ready one cycle later.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                bank_st[b] <= TP_EMPTY;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (in_fire && (wb == 1'(b))) begin
                    bank_st[b] <= wr_last ? TP_FULL : TP_FILLING;
                end else if (out_fire && (rb == 1'(b))) begin
                    bank_st[b] <= rd_last ? TP_EMPTY : TP_DRAINING;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    for (genvar b = 0; b < 2; b++) begin : g_bank
        if (b < NB) begin : g_inst
            dct_tp_bank #(
                .DATA_W (DATA_W)
            ) u_bank (
                .clk    (clk),
                .we     (in_fire && (wb == 1'(b))),
                .row    (wr_row),
                .wr_vec (wr_vec),
                .col    (rd_col),
                .rd_vec (rd_vec[b])
            );
        end else begin : g_none
            assign rd_vec[b] = '0;
        end
    end

    // ------------------------------------------------------------------
    // Output mux; words forced to zero whenever no column is offered so
    // downstream never sees stale or unwritten storage.
    // ------------------------------------------------------------------
    assign rd_sel  = rd_vec[rb];
    assign out_vec = out_valid ? rd_sel : '0;

    assign out0 = out_vec[0];
    assign out1 = out_vec[1];
    assign out2 = out_vec[2];
    assign out3 = out_vec[3];
    assign out4 = out_vec[4];
    assign out5 = out_vec[5];
    assign out6 = out_vec[6];
    assign out7 = out_vec[7];

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    a_out_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_vec)));

    a_no_bank_clash : assert property (@(posedge clk) disable iff (!rst_n)
        !(in_fire && out_fire && (wb == rb)));

endmodule

// File: tb/tb_dct8_transpose_pp.sv
// Scoreboard bench for dct8_transpose_pp: a reference model transposes each
// completed 8-row block into 8 expected columns; a monitor pops one per
// output handshake. Directed phases cover reset, latency, streaming,
// backpressure and reset mid-block; a final phase uses random stalls.
module tb_dct8_transpose_pp;

    localparam int W = 32;

`ifdef DCT_TP_SINGLE_BANK_EN
    localparam bit SINGLE = 1'b1;
`else
    localparam bit SINGLE = 1'b0;
`endif

    // Expected in-flight capacity before the writer stalls with out_ready=0.
    localparam int BP_ROWS  = SINGLE ? 8 : 16;
    localparam int RST_ROWS = SINGLE ? 5 : 11;

    typedef logic [7:0][W-1:0] vec_t;

    logic   clk      = 1'b0;
    logic   rst_n    = 1'b1;
    logic   in_valid = 1'b0;
    logic   out_ready = 1'b0;
    vec_t   in_vec   = '0;
    logic   in_ready;
    logic   out_valid;
    logic [W-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
    vec_t   out_vec;

    always #5 clk = ~clk;

    dct8_transpose_pp #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in_vec[0]),
        .in1       (in_vec[1]),
        .in2       (in_vec[2]),
        .in3       (in_vec[3]),
        .in4       (in_vec[4]),
        .in5       (in_vec[5]),
        .in6       (in_vec[6]),
        .in7       (in_vec[7]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out5      (out5),
        .out6      (out6),
        .out7      (out7)
    );

    assign out_vec = {out7, out6, out5, out4, out3, out2, out1, out0};

    int     n_checks = 0;
    int     n_pass   = 0;
    int     stall_cycles;
    int     run_len;
    bit     rnd_done;

    // Reference model: rows collect into a plain 8x8 array; a complete block
    // yields its columns in order.
    vec_t         exp_q [$];
    logic [W-1:0] blk [8][8];
    int           rows_in = 0;
    vec_t         mon_exp;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_accept(input vec_t row);
        vec_t col;
        for (int c = 0; c < 8; c++) blk[rows_in][c] = row[c];
        rows_in++;
        if (rows_in == 8) begin
            for (int c = 0; c < 8; c++) begin
                for (int r = 0; r < 8; r++) col[r] = blk[r][c];
                exp_q.push_back(col);
            end
            rows_in = 0;
        end
    endtask

    function automatic vec_t rand_row();
        vec_t v;
        for (int c = 0; c < 8; c++) v[c] = $urandom;
        return v;
    endfunction

    // Offer one row; returns #1 after the accepting edge with in_valid low.
    task automatic send_row(input vec_t row);
        int  waits = 0;
        bit  ok;
        bit  timed_out = 1'b0;
        in_vec   = row;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            if (ok) break;
            waits++;
            if (waits > 300) begin
                timed_out = 1'b1;
                break;
            end
        end
        if (timed_out) check("send_timeout", 1'b0, 1'b1);
        else model_accept(row);
        #1;
        in_valid = 1'b0;
        stall_cycles += waits;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake must match the next expected column.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_column", 1'b1, 1'b0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("column", out_vec, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t row;
        vec_t exp0;
        int   t;

        // ---------------- reset ----------------
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data",  out_vec,   '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready",  in_ready,  1'b1);
        check("post_rst_out_valid", out_valid, 1'b0);
        check("post_rst_out_data",  out_vec,   '0);
        @(posedge clk);
        #1;

        // ---------------- single block, in_c = 8r+c ----------------
        stall_cycles = 0;
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) row[c] = W'(8 * r + c);
            send_row(row);
            if (r == 6) check("no_early_valid", out_valid, 1'b0);
        end
        // Now in the cycle right after the row-7 edge.
        for (int r = 0; r < 8; r++) exp0[r] = W'(8 * r);
        check("latency_valid", out_valid, 1'b1);
        check("latency_col0",  out_vec,   exp0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("burst_valid", out_valid, 1'b1);
        end
        @(negedge clk);
        check("burst_end_valid", out_valid, 1'b0);
        check("burst_end_data",  out_vec,   '0);
        check("single_drained",  exp_q.size(), 0);
        @(posedge clk);
        #1;

        // ---------------- streaming, 4 blocks back to back ----------------
        stall_cycles = 0;
        run_len = 0;
        fork
            begin
                for (int i = 0; i < 32; i++) send_row(rand_row());
            end
            begin
                t = 0;
                @(negedge clk);
                while (!out_valid && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                while (out_valid && run_len < 100) begin
                    run_len++;
                    @(negedge clk);
                end
            end
        join
        check("stream_in_stalls", stall_cycles, SINGLE ? 24 : 0);
        check("stream_out_run",   run_len,      SINGLE ? 8 : 32);
        wait_drain("stream_drain");

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        for (int i = 0; i < BP_ROWS; i++) send_row(rand_row());
        check("bp_in_ready_low", in_ready, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_data",  out_vec,   exp_q[0]);
            check("bp_hold_ready", in_ready,  1'b0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("bp_drain_in_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        check("bp_in_ready_rise", in_ready, 1'b1);
        wait_drain("bp_drain");

        // ---------------- reset mid-block ----------------
        out_ready = 1'b0;
        for (int i = 0; i < RST_ROWS; i++) send_row(rand_row());
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  in_ready,  1'b1);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_data",  out_vec,   '0);
        exp_q.delete();
        rows_in = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_in_ready",  in_ready,  1'b1);
        check("mid_rel_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_row(rand_row());
        wait_drain("fresh_block_drain");

        // ---------------- random stalls ----------------
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 48; i++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        @(posedge clk);
                        #1;
                    end
                    send_row(rand_row());
                end
                wait_drain("random_drain");
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("final_idle_valid", out_valid, 1'b0);
        check("final_rows_pending", rows_in, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
